// File: rtl/vga_pkg.sv
// vga_pkg: default 640x480@60 timing, HP image window size and the pipeline record shared by
// the scanout top and its timing generator.
package vga_pkg;
    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam int WIN_W        = 512;
    localparam int WIN_H        = 256;
    localparam int CNT_W        = 11;
    localparam int PIPE         = 3;
    localparam logic SYNC_ACTIVE = 1'b0;

    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
        logic vb;
        logic win;
    } vid_t;

    localparam vid_t VID_RST = '{hs: ~SYNC_ACTIVE, vs: ~SYNC_ACTIVE, de: 1'b0, vb: 1'b0, win: 1'b0};
endpackage

// File: rtl/vga_timing.sv
// vga_timing: free-running h/v counters with raw (undelayed) sync, active-area and vblank decode.
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             hs,
    output logic             vs,
    output logic             act,
    output logic             vb
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [CNT_W-1:0] HS_ON  = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_OFF = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_ON  = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_OFF = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == CNT_W'(H_TOTAL - 1)) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == CNT_W'(V_TOTAL - 1)) ? '0 : v_cnt + CNT_W'(1);
        end else begin
            h_cnt <= h_cnt + CNT_W'(1);
        end
    end

    assign hs  = (h_cnt >= HS_ON && h_cnt < HS_OFF) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    assign vs  = (v_cnt >= VS_ON && v_cnt < VS_OFF) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    assign act = h_cnt < CNT_W'(H_ACTIVE) && v_cnt < CNT_W'(V_ACTIVE);
    assign vb  = v_cnt >= CNT_W'(V_ACTIVE);
endmodule

// File: rtl/hp_fb_scanout.sv
// hp_fb_scanout: reads the 512x256 mono HP image out of the frame buffer, centred in the VGA
// frame, serialises each byte MSB first and delays all video signals to line up with the pixels.
module hp_fb_scanout
    import vga_pkg::*;
#(
    parameter int ADDR_WIDTH = 14,
    parameter int H_ACTIVE   = H_ACTIVE_DEF,
    parameter int H_FP       = H_FP_DEF,
    parameter int H_SYNC     = H_SYNC_DEF,
    parameter int H_BP       = H_BP_DEF,
    parameter int V_ACTIVE   = V_ACTIVE_DEF,
    parameter int V_FP       = V_FP_DEF,
    parameter int V_SYNC     = V_SYNC_DEF,
    parameter int V_BP       = V_BP_DEF,
    parameter int WIN_X      = 64,
    parameter int WIN_Y      = 112
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] raddr,
    input  logic [7:0]            rdata,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  de,
    output logic                  pixel,
    output logic                  vblank
);
    logic [CNT_W-1:0]  h_cnt, v_cnt, x, y;
    logic              hs, vs, act, vb, win, fetch;
    logic [1:0]        ld;
    logic [7:0]        shreg;
    vid_t              cur;
    vid_t [PIPE-1:0]   pipe;

    vga_timing #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .clk(clk), .rst_n(rst_n), .h_cnt(h_cnt), .v_cnt(v_cnt),
        .hs(hs), .vs(vs), .act(act), .vb(vb)
    );

    // Underflow wraps to a large unsigned value, so a single compare bounds each side.
    assign x     = h_cnt - CNT_W'(WIN_X);
    assign y     = v_cnt - CNT_W'(WIN_Y);
    assign win   = x < CNT_W'(WIN_W) && y < CNT_W'(WIN_H);
    assign fetch = win && x[2:0] == 3'd0;
    assign cur   = '{hs: hs, vs: vs, de: act, vb: vb, win: win};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            raddr <= '0;
            ld    <= '0;
            shreg <= '0;
            pipe  <= {PIPE{VID_RST}};
        end else begin
            if (fetch)
                raddr <= ADDR_WIDTH'({y[7:0], x[8:3]});
            ld    <= {ld[0], fetch};
            shreg <= ld[1] ? rdata : {shreg[6:0], 1'b0};
            pipe  <= {pipe[PIPE-2:0], cur};
        end
    end

    assign hsync  = pipe[PIPE-1].hs;
    assign vsync  = pipe[PIPE-1].vs;
    assign de     = pipe[PIPE-1].de;
    assign vblank = pipe[PIPE-1].vb;
    assign pixel  = shreg[7] & pipe[PIPE-1].win;
endmodule

// File: tb/tb_hp_fb_scanout.sv
// tb_hp_fb_scanout: directed checks of timing, fetch addresses, unpacking, window edges and reset,
// using a shrunk frame (552x10) so whole frames fit in a few thousand cycles.
module tb_hp_fb_scanout;
    localparam int HT = 552;
    localparam int FT = HT * 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [13:0] raddr;
    logic [7:0]  rdata = 8'h00;
    logic        hsync, vsync, de, pixel, vblank;
    logic [7:0]  mem [16384];
    logic [7:0]  pat;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    hp_fb_scanout #(
        .ADDR_WIDTH(14),
        .H_ACTIVE(520), .H_FP(8), .H_SYNC(16), .H_BP(8),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .WIN_X(4), .WIN_Y(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata),
        .hsync(hsync), .vsync(vsync), .de(de), .pixel(pixel), .vblank(vblank)
    );

    always #5 clk = ~clk;

    // One-cycle-latency buffer model; cyc mirrors the DUT counter cycle index.
    always @(posedge clk) begin
        rdata <= mem[raddr];
        cyc   <= rst_n ? cyc + 1 : 0;
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s at cyc %0d: observed %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic at(input int t);
        int guard = 0;
        while (cyc != t && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != t) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout waiting for cyc %0d (now %0d)", t, cyc);
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_hsync"},  16'(hsync),  16'd1);
        chk({tag, "_vsync"},  16'(vsync),  16'd1);
        chk({tag, "_de"},     16'(de),     16'd0);
        chk({tag, "_pixel"},  16'(pixel),  16'd0);
        chk({tag, "_vblank"}, 16'(vblank), 16'd0);
        chk({tag, "_raddr"},  16'(raddr),  16'd0);
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
        mem[0]  = 8'hA5;
        mem[63] = 8'h81;
        for (int i = 0; i < 64; i++) mem[64 + i] = 8'hFF;
        pat = 8'hA5;

        repeat (5) @(negedge clk);
        chk_reset_outs("rst");
        rst_n = 1'b1;

        at(2);    chk("de_pre",  16'(de), 16'd0); chk("hs_pre", 16'(hsync), 16'd1);
        at(3);    chk("de_rise", 16'(de), 16'd1);
        at(522);  chk("de_last", 16'(de), 16'd1);
        at(523);  chk("de_fall", 16'(de), 16'd0);
        at(530);  chk("hs_before", 16'(hsync), 16'd1);
        at(531);  chk("hs_fall",   16'(hsync), 16'd0);
        at(546);  chk("hs_last",   16'(hsync), 16'd0);
        at(547);  chk("hs_rise",   16'(hsync), 16'd1);
        at(655);  chk("above_win_pix", 16'(pixel), 16'd0); chk("above_win_de", 16'(de), 16'd1);

        at(2 * HT + 6); chk("l2_left_edge", 16'(pixel), 16'd0);
        for (int i = 0; i < 8; i++) begin
            at(2 * HT + 7 + i);
            chk($sformatf("a5_bit%0d", i), 16'(pixel), 16'(pat[7 - i]));
        end
        at(2 * HT + 509); chk("raddr_row0_col63", 16'(raddr), 16'd63);
        at(2 * HT + 511); chk("b81_first", 16'(pixel), 16'd1);
        at(2 * HT + 512); chk("b81_second", 16'(pixel), 16'd0);
        at(2 * HT + 518); chk("b81_last", 16'(pixel), 16'd1);
        at(2 * HT + 519); chk("l2_right_out", 16'(pixel), 16'd0);

        at(3 * HT + 6);   chk("ff_x63",  16'(pixel), 16'd0);
        at(3 * HT + 7);   chk("ff_x64",  16'(pixel), 16'd1);
        at(3 * HT + 509); chk("raddr_row1_col63", 16'(raddr), 16'd127);
        at(3 * HT + 518); chk("ff_x575", 16'(pixel), 16'd1);
        at(3 * HT + 519); chk("ff_x576", 16'(pixel), 16'd0);

        at(4 * HT);       chk("raddr_hold", 16'(raddr), 16'd127);
        at(4 * HT + 5);   chk("raddr_row2_col0", 16'(raddr), 16'd128);
        at(4 * HT + 103); chk("zero_row_pix", 16'(pixel), 16'd0); chk("zero_row_de", 16'(de), 16'd1);

        at(6 * HT + 2);   chk("vb_before", 16'(vblank), 16'd0);
        at(6 * HT + 3);   chk("vb_rise",   16'(vblank), 16'd1); chk("de_vblank", 16'(de), 16'd0);
        at(7 * HT + 2);   chk("vs_before", 16'(vsync), 16'd1);
        at(7 * HT + 3);   chk("vs_fall",   16'(vsync), 16'd0);
        at(9 * HT + 2);   chk("vs_last",   16'(vsync), 16'd0);
        at(9 * HT + 3);   chk("vs_rise",   16'(vsync), 16'd1);
        at(9 * HT + 509); chk("raddr_row7_col63", 16'(raddr), 16'd511);
        at(FT + 2);       chk("vb_last",   16'(vblank), 16'd1);
        at(FT + 3);       chk("vb_fall",   16'(vblank), 16'd0);

        at(FT + 2 * HT + 5); chk("raddr_wrap", 16'(raddr), 16'd0);
        at(FT + 2 * HT + 7); chk("f2_a5_bit0", 16'(pixel), 16'd1);

        at(FT + 5 * HT + 300);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_cyc", 16'(cyc), 16'd0);
        chk_reset_outs("mid_rst");
        rst_n = 1'b1;
        at(3);            chk("mid_de_rise", 16'(de), 16'd1);
        at(2 * HT + 7);   chk("mid_a5_bit0", 16'(pixel), 16'd1);
        at(7 * HT + 2);   chk("mid_vs_before", 16'(vsync), 16'd1);
        at(7 * HT + 3);   chk("mid_vs_fall",   16'(vsync), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
